// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared definitions for the UART transmitter (and its uart_rx sibling):
//   - default line rate and clock frequency
//   - frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   - bit-period calculation (clk cycles per bit, integer truncated)
// Optional feature macro used by the importing RTL: UART_TX_PARITY_EN.
package uart_tx_pkg;

    localparam int DEF_BAUD    = 9600;
    localparam int DEF_CLK_FRE = 50_000_000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Clock cycles per bit; fractional part is dropped.
    function automatic int baud_cnt(input int clk_fre, input int baud);
        return clk_fre / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if
// Byte-level valid/ready handshake into the UART transmitter.
//   data       : byte to send, sampled only when data_valid & data_ready
//   data_valid : producer requests a transfer
//   data_ready : transmitter idle, accepts a byte this cycle
// Modports: master (user logic / TX FIFO), slave (uart_tx).
interface uart_tx_if;

    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        output data_ready
    );

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Bit-period timer. Counts 0..BAUD_CNT-1 while enable is high and pulses
// bit_tick during the last cycle of each bit period. Held at 0 while
// enable is low, so every enabled stretch starts on a full bit period.
// Ports:
//   clk      : system clock
//   rst      : synchronous reset, active-high
//   enable   : run the counter
//   bit_tick : one-cycle pulse at count == BAUD_CNT-1
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int BAUD    = DEF_BAUD,
    parameter int CLK_FRE = DEF_CLK_FRE
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic bit_tick
);

    localparam int BAUD_CNT = baud_cnt(CLK_FRE, BAUD);
    localparam int CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (enable && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign bit_tick = enable && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// 8N1 UART transmitter. Accepts one byte per valid/ready handshake and
// shifts it out LSB first between one start bit (0) and one stop bit (1).
// tx is a flop fed from the next-state decode, so it is glitch-free and
// can drive a pin directly; it falls on the handshake edge itself.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit
// (^byte ^ PARITY_ODD) between the data bits and the stop bit.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high (wins over a same-cycle handshake)
//   bus  : uart_tx_if.slave (data, data_valid in; data_ready out)
//   tx   : serial line, idles high
//   busy : frame in progress, complement of data_ready
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUD       = DEF_BAUD,
    parameter int CLK_FRE    = DEF_CLK_FRE,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic       busy
);

    if (CLK_FRE / BAUD < 2) begin : g_bad_ratio
        $error("uart_tx: CLK_FRE/BAUD must be at least 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       tx_q, tx_d;
    logic       bit_tick;
    logic       handshake;
`ifdef UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    uart_baud_gen #(
        .BAUD    (BAUD),
        .CLK_FRE (CLK_FRE)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .enable   (state_q != ST_IDLE),
        .bit_tick (bit_tick)
    );

    assign bus.data_ready = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign handshake      = bus.data_valid && (state_q == ST_IDLE);
    assign tx             = tx_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d   = ST_START;
                    shift_d   = bus.data;
                    bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                    // Shift register is consumed bit by bit, so keep the
                    // parity of the byte from the handshake.
                    par_d     = (^bus.data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            ST_START: begin
                if (bit_tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_tick) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level follows the state being entered, giving a registered tx.
        unique case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
// Directed bench for uart_tx with a short bit period (16 clk per bit).
// Covers reset idle, single byte, back-to-back frames, valid while busy,
// reset mid-frame and reset coinciding with a handshake.
module tb_uart_tx;

    localparam int CLK_FRE = 1_000_000;
    localparam int BAUD    = 62_500;
    localparam int BC      = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS   = 11;
`else
    localparam int NBITS   = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic busy;

    uart_tx_if bus ();

    uart_tx #(
        .BAUD       (BAUD),
        .CLK_FRE    (CLK_FRE),
        .PARITY_ODD (0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .tx   (tx),
        .busy (busy)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Expected line level for frame bit k: start, 8 data LSB first, [parity], stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        logic [10:0] f;
`ifdef UART_TX_PARITY_EN
        f = {1'b1, ^b, b, 1'b0};
`else
        f = {1'b1, 1'b1, b, 1'b0};
`endif
        return f[k];
    endfunction

    task automatic wait_ready();
        int i = 0;
        while (!bus.data_ready && i < 400) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("ready_wait", bus.data_ready, 1);
    endtask

    // Leaves the caller #1 after the handshake edge.
    task automatic send(input logic [7:0] b);
        wait_ready();
        check("idle_tx", tx, 1);
        bus.data       = b;
        bus.data_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        bus.data       = ~b;
        check("tx_fall", tx, 0);
        check("busy_hs", busy, 1);
        check("ready_hs", bus.data_ready, 0);
    endtask

    // Called #1 after the handshake edge; samples mid-bit, then checks that
    // data_ready rises exactly NBITS*BC cycles after tx fell.
    task automatic check_frame(input logic [7:0] b, input bit poke);
        for (int k = 0; k < NBITS; k++) begin
            repeat (BC / 2) @(posedge clk);
            #1;
            check($sformatf("byte%02h_bit%0d", b, k), tx, frame_bit(b, k));
            if (k == NBITS - 1) begin
                repeat (BC / 2 - 1) @(posedge clk);
                #1;
                check("ready_last_stop", bus.data_ready, 0);
                @(posedge clk);
                #1;
                check("ready_end", bus.data_ready, 1);
                check("tx_end", tx, 1);
            end else if (poke && k == 4) begin
                bus.data       = 8'h3C;
                bus.data_valid = 1'b1;
                @(posedge clk);
                #1;
                bus.data_valid = 1'b0;
                check("poke_busy", busy, 1);
                repeat (BC / 2 - 1) @(posedge clk);
            end else begin
                repeat (BC / 2) @(posedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t limit reached", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data       = 8'h00;
        bus.data_valid = 1'b0;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_ready", bus.data_ready, 1);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle_tx", tx, 1);
            check("idle_ready", bus.data_ready, 1);
            check("idle_busy", busy, 0);
        end

        // Single byte
        send(8'hA5);
        check_frame(8'hA5, 1'b0);

        // Back-to-back with data_valid held high
        wait_ready();
        bus.data       = 8'h00;
        bus.data_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.data = 8'hFF;
        check("b2b_fall0", tx, 0);
        check_frame(8'h00, 1'b0);
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        check("b2b_fall1", tx, 0);
        check("b2b_busy1", busy, 1);
        check_frame(8'hFF, 1'b0);

        // data_valid while busy is ignored
        send(8'h81);
        check_frame(8'h81, 1'b1);
        for (int i = 0; i < 2 * BC; i++) begin
            @(posedge clk);
            #1;
            check("no_3c_tx", tx, 1);
            check("no_3c_ready", bus.data_ready, 1);
        end

        // Reset during data bit 3
        send(8'h55);
        repeat (4 * BC + BC / 2) @(posedge clk);
        #1;
        check("mid_bit3", tx, frame_bit(8'h55, 4));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_ready", bus.data_ready, 1);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        send(8'h0F);
        check_frame(8'h0F, 1'b0);

        // Reset and handshake in the same cycle: byte dropped
        bus.data       = 8'hAA;
        bus.data_valid = 1'b1;
        rst            = 1'b1;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rsths_tx", tx, 1);
            check("rsths_ready", bus.data_ready, 1);
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
